// File: rtl/byte_word_packer.sv
// byte_word_packer
//   Packs an 8-bit valid/ready byte stream into WORD_BYTES-wide words with a
//   byte-keep mask and a frame-last flag. The accumulator and the output
//   register are separate, so filling continues while a finished word waits
//   downstream. Sustained throughput is one byte per clock.
//
// Parameters
//   WORD_BYTES  bytes per output word (>= 2)
//   CNT_W       width of the wrapping sent-word counter
//
// Ports
//   clk, rst    clock; synchronous active-high reset
//   in_data     input byte
//   in_valid    input byte valid
//   in_last     input byte ends a frame
//   in_ready    packer accepts a byte this cycle
//   out_data    packed word, lane 0 (first byte) in bits [7:0]
//   out_keep    lane-filled mask
//   out_last    word ends a frame
//   out_valid   output word valid
//   out_ready   downstream accepts the word
//   word_cnt    words transferred on the output (wraps)
//   out_parity  even parity per lane (only with BYTE_WORD_PACKER_PARITY_EN)
//
// Configuration macro
//   BYTE_WORD_PACKER_PARITY_EN  adds the out_parity output port.
module byte_word_packer #(
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]   out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        word_cnt
`ifdef BYTE_WORD_PACKER_PARITY_EN
  ,
  output logic [WORD_BYTES-1:0]   out_parity
`endif
);

  localparam int LANE_W = $clog2(WORD_BYTES + 1);

  typedef enum logic {EMPTY, FILL} fillState_t;

  fillState_t                state;
  logic [LANE_W-1:0]         laneCnt;
  logic [8*WORD_BYTES-1:0]   accData;
  logic [WORD_BYTES-1:0]     accKeep;
  logic                      wouldComplete;
  logic                      inAccept;
  logic                      outAccept;
  logic [8*WORD_BYTES-1:0]   mergedData;
  logic [WORD_BYTES-1:0]     mergedKeep;

  // Even parity of each byte lane; unfilled lanes are zero so their bit is 0.
  function automatic logic [WORD_BYTES-1:0] laneParity(input logic [8*WORD_BYTES-1:0] d);
    logic [WORD_BYTES-1:0] p;
    p = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // A byte completes the word when it fills the top lane or closes a frame.
  assign wouldComplete = (laneCnt == LANE_W'(WORD_BYTES - 1)) || in_last;
  // Only a completing byte needs the output register; it may load in the
  // same edge the current word drains.
  assign in_ready  = !wouldComplete || !out_valid || out_ready;
  assign inAccept  = in_valid && in_ready;
  assign outAccept = out_valid && out_ready;

  // Accumulator contents with the incoming byte dropped into lane[laneCnt].
  // Only committed on an accept, so in_data never reaches an unfilled lane
  // when in_valid is low.
  always_comb begin
    mergedData = (state == EMPTY) ? '0 : accData;
    mergedKeep = (state == EMPTY) ? '0 : accKeep;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (laneCnt == LANE_W'(i)) begin
        mergedData[8*i +: 8] = in_data;
        mergedKeep[i]        = 1'b1;
      end
    end
  end

  // Stage boundary: accumulator and output register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      laneCnt   <= '0;
      accData   <= '0;
      accKeep   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      word_cnt  <= '0;
`ifdef BYTE_WORD_PACKER_PARITY_EN
      out_parity <= '0;
`endif
    end else begin
      if (outAccept) begin
        out_valid <= 1'b0;
        word_cnt  <= word_cnt + CNT_W'(1);
      end
      if (inAccept) begin
        if (wouldComplete) begin
          // Overrides the drain above when both happen: new word replaces old.
          out_data  <= mergedData;
          out_keep  <= mergedKeep;
          out_last  <= in_last;
          out_valid <= 1'b1;
`ifdef BYTE_WORD_PACKER_PARITY_EN
          out_parity <= laneParity(mergedData);
`endif
          laneCnt   <= '0;
          accData   <= '0;
          accKeep   <= '0;
          state     <= EMPTY;
        end else begin
          accData   <= mergedData;
          accKeep   <= mergedKeep;
          laneCnt   <= laneCnt + LANE_W'(1);
          state     <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// tb_byte_word_packer
//   Directed and randomized bench for byte_word_packer (WORD_BYTES=4, CNT_W=4
//   so the word counter wraps within the run). A queue-based reference model
//   tracks the bytes of the partial word and the word held at the output.
module tb_byte_word_packer;

  localparam int WB = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [8*WB-1:0] out_data;
  logic [WB-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] word_cnt;
`ifdef BYTE_WORD_PACKER_PARITY_EN
  logic [WB-1:0] out_parity;
`endif

  byte_word_packer #(.WORD_BYTES(WB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt)
`ifdef BYTE_WORD_PACKER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  logic [7:0]    mPart[$];
  logic          mValid;
  logic          mShow;      // output contents are defined (held word or reset zeros)
  logic [8*WB-1:0] mData;
  logic [WB-1:0] mKeep;
  logic          mLast;
  logic [WB-1:0] mPar;
  int            mCnt;
  int            mDelivered;
  logic          sawRdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPart.delete();
    mValid = 1'b0;
    mShow  = 1'b1;
    mData  = '0;
    mKeep  = '0;
    mLast  = 1'b0;
    mPar   = '0;
    mCnt   = 0;
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_out_keep", 64'(out_keep), 64'd0);
  endtask

  // One clock: drive inputs at the falling edge, check just after, then
  // advance the model across the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic ordy);
    logic comp, expRdy, inAcc, outAcc;
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    comp   = (mPart.size() == WB - 1) || l;
    expRdy = !comp || !mValid || ordy;
    chk("in_ready", 64'(in_ready), 64'(expRdy));
    chk("out_valid", 64'(out_valid), 64'(mValid));
    chk("word_cnt", 64'(word_cnt), 64'(mCnt % (1 << CW)));
    if (mShow) begin
      chk("out_data", 64'(out_data), 64'(mData));
      chk("out_keep", 64'(out_keep), 64'(mKeep));
      chk("out_last", 64'(out_last), 64'(mLast));
`ifdef BYTE_WORD_PACKER_PARITY_EN
      chk("out_parity", 64'(out_parity), 64'(mPar));
`endif
    end
    sawRdy = in_ready;
    inAcc  = v && expRdy;
    outAcc = mValid && ordy;
    @(negedge clk);
    if (outAcc) begin
      mValid = 1'b0; mShow = 1'b0; mCnt++; mDelivered++;
    end
    if (inAcc) begin
      mPart.push_back(d);
      if (comp) begin
        mData = '0; mKeep = '0; mPar = '0;
        for (int i = 0; i < mPart.size(); i++) begin
          mData = mData | ((8*WB)'(mPart[i]) << (8*i));
          mKeep[i] = 1'b1;
          mPar[i]  = ^mPart[i];
        end
        mLast = l; mValid = 1'b1; mShow = 1'b1;
        mPart.delete();
      end
    end
  endtask

  initial begin
    int base;
    int tries;
    logic allRdy;
    logic [7:0] rb;
    mDelivered = 0;
    modelReset();
    @(negedge clk);
    doReset();

    // Full word 11 22 33 44
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    chk("w1_data", 64'(out_data), 64'h44332211);
    chk("w1_keep", 64'(out_keep), 64'hF);
    chk("w1_last", 64'(out_last), 64'd0);
    step(0, 8'h00, 0, 1);
    chk("w1_cnt", 64'(word_cnt), 64'd1);

    // Short frame AA BB, then single-byte frame CC
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
    chk("w2_data", 64'(out_data), 64'h0000BBAA);
    chk("w2_keep", 64'(out_keep), 64'h3);
    chk("w2_last", 64'(out_last), 64'd1);
    step(1, 8'hCC, 1, 1);
    chk("w3_keep", 64'(out_keep), 64'h1);
    step(1, 8'h07, 1, 1);   // back-to-back single-lane word, parity 1 on lane 0
    chk("w4_keep", 64'(out_keep), 64'h1);
`ifdef BYTE_WORD_PACKER_PARITY_EN
    chk("w4_parity", 64'(out_parity), 64'h1);
`endif
    step(0, 8'h00, 0, 1);

    // Stall: out_ready low while streaming 8 bytes
    for (int b = 1; b <= 8; b++) step(1, 8'(b), 0, 0);
    chk("stall_rdy", 64'(sawRdy), 64'd0);
    chk("stall_hold", 64'(out_data), 64'h04030201);
    tries = 0;
    do begin
      step(1, 8'h08, 0, 1);
      tries++;
    end while (!sawRdy && tries < 10);
    chk("stall_release", 64'(sawRdy), 64'd1);
    chk("stall_w2", 64'(out_data), 64'h08070605);
    repeat (2) step(0, 8'h00, 0, 1);

    // Continuous stream of 64 bytes
    base = mDelivered;
    allRdy = 1'b1;
    for (int b = 0; b < 64; b++) begin
      step(1, 8'($urandom), 0, 1);
      allRdy = allRdy & sawRdy;
    end
    step(0, 8'h00, 0, 1);
    chk("stream_rdy", 64'(allRdy), 64'd1);
    chk("stream_words", 64'(mDelivered - base), 64'd16);

    // Reset in the middle of a word
    step(1, 8'hE1, 0, 1); step(1, 8'hE2, 0, 1);
    doReset();
    step(1, 8'h51, 0, 1); step(1, 8'h52, 0, 1);
    step(1, 8'h53, 0, 1); step(1, 8'h54, 0, 1);
    chk("rstmid_data", 64'(out_data), 64'h54535251);
    chk("rstmid_keep", 64'(out_keep), 64'hF);
    step(0, 8'h00, 0, 1);

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      rb = 8'($urandom);
      if ($urandom_range(0, 3) != 0)
        step(1, rb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
      else
        step(0, rb, 0, ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(0, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
